// File: rtl/input_queue.sv
// Debounced push-button input queue: synchronizes the button and switches, pushes the switch word into a FIFO on each accepted press, and pops one word per CPU request.
// Latency: press accepted 2 sync cycles + DEBOUNCE_CYCLES after the edge; push is written one cycle later; pop data/valid appear the cycle after rd_req.
// Backpressure: none toward the button; a push into a full FIFO (without a simultaneous pop) is dropped and latches overflow; pop on empty is ignored.
// Optional: define INPUT_QUEUE_SIGN_EXT_EN to sign-extend the switch value instead of zero-extending it.
module input_queue #(
  parameter int DATA_WIDTH      = 16,
  parameter int IN_WIDTH        = 4,
  parameter int DEPTH_LOG2      = 3,
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_push,
  input  logic [IN_WIDTH-1:0]   sw,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]         DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  // Synchronizer stages for the button and the switch bank
  logic                btn_s1;
  logic                btn_s;
  logic [IN_WIDTH-1:0] sw_s1;
  logic [IN_WIDTH-1:0] sw_s;

  // Debouncer state
  logic          btn_db;
  logic          btn_db_q;
  logic [CW-1:0] db_cnt;

  // FIFO storage and pointers
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic                  push;
  logic                  pop;
  logic                  push_acc;
  logic                  drop;
  logic [DEPTH_LOG2:0]   count_next;
  logic [DATA_WIDTH-1:0] push_data;

  // Double-flop the asynchronous button and switches into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
      sw_s1  <= '0;
      sw_s   <= '0;
    end else begin
      btn_s1 <= btn_push;
      btn_s  <= btn_s1;
      sw_s1  <= sw;
      sw_s   <= sw_s1;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  // Push on the rising edge of the debounced level; pop only when something is stored
  always_comb begin
    push     = btn_db & ~btn_db_q;
    pop      = rd_req && (count != '0);
    push_acc = push && ((count != DEPTH_CNT) || pop);
    drop     = push && (count == DEPTH_CNT) && !pop;
`ifdef INPUT_QUEUE_SIGN_EXT_EN
    push_data = DATA_WIDTH'($signed(sw_s));
`else
    push_data = DATA_WIDTH'(sw_s);
`endif
    count_next = count;
    if (push_acc && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push_acc) begin
      count_next = count - CNT_ONE;
    end
  end

  // Storage write; entries need no reset since the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, registered flags and pop output
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= pop;
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next == DEPTH_CNT);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_queue.sv
// Directed self-checking bench for input_queue with a short debounce and a 4-entry FIFO.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_input_queue;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int DL = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_push;
  logic [IW-1:0] sw;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic          cap_valid;
  logic [DW-1:0] cap_data;
  logic [DL:0]   cap_count;
  logic          cap_ovf;

  input_queue #(
    .DATA_WIDTH(DW), .IN_WIDTH(IW), .DEPTH_LOG2(DL), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .btn_push(btn_push), .sw(sw), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ext(input logic [IW-1:0] v);
`ifdef INPUT_QUEUE_SIGN_EXT_EN
    return {{(DW-IW){v[IW-1]}}, v};
`else
    return {{(DW-IW){1'b0}}, v};
`endif
  endfunction

  // Full debounced press and release; optionally raise rd_req so the pop lands on the push edge
  task automatic press(input logic [IW-1:0] v, input bit with_pop);
    sw       = v;
    btn_push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd_req = (with_pop && i == 5);
      if (i == 6) begin
        cap_valid = rd_valid;
        cap_data  = rd_data;
        cap_count = count;
        cap_ovf   = overflow;
      end
    end
    btn_push = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [DW-1:0] exp);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; btn_push = 1'b0; sw = '0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);

    // Pop on empty
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("idle_pop_valid", 32'(rd_valid), 32'd0);

    // Short glitch: 3 cycles high is below the debounce threshold
    btn_push = 1'b1;
    repeat (3) @(negedge clk);
    btn_push = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_count", 32'(count), 32'd0);

    // Held press pushes exactly once
    press(4'hA, 1'b0);
    check("press_count", 32'(count), 32'd1);
    check("press_empty", 32'(empty), 32'd0);
    pop_expect("pop_A", ext(4'hA));
    @(negedge clk);
    check("pop_A_pulse", 32'(rd_valid), 32'd0);

    // Order and pointer wrap
    press(4'd1, 1'b0); press(4'd2, 1'b0); press(4'd3, 1'b0);
    pop_expect("wrap_1", ext(4'd1));
    pop_expect("wrap_2", ext(4'd2));
    press(4'd4, 1'b0); press(4'd5, 1'b0); press(4'd6, 1'b0);
    check("wrap_count", 32'(count), 32'd4);
    check("wrap_full", 32'(full), 32'd1);
    pop_expect("wrap_3", ext(4'd3));
    pop_expect("wrap_4", ext(4'd4));
    pop_expect("wrap_5", ext(4'd5));
    pop_expect("wrap_6", ext(4'd6));
    @(negedge clk);
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_full0", 32'(full), 32'd0);
    check("wrap_count0", 32'(count), 32'd0);

    // Overflow
    for (int v = 7; v <= 11; v++) press(IW'(v), 1'b0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    pop_expect("ovf_7", ext(4'd7));
    pop_expect("ovf_8", ext(4'd8));
    pop_expect("ovf_9", ext(4'd9));
    pop_expect("ovf_10", ext(4'd10));
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("ovf_empty_pop", 32'(rd_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Simultaneous push and pop while full
    for (int v = 7; v <= 10; v++) press(IW'(v), 1'b0);
    check("sim_full", 32'(full), 32'd1);
    press(4'd12, 1'b1);
    check("sim_full_valid", 32'(cap_valid), 32'd1);
    check("sim_full_data", 32'(cap_data), 32'(ext(4'd7)));
    check("sim_full_count", 32'(cap_count), 32'd4);
    check("sim_full_ovf", 32'(cap_ovf), 32'd0);
    pop_expect("sim_8", ext(4'd8));
    pop_expect("sim_9", ext(4'd9));
    pop_expect("sim_10", ext(4'd10));
    pop_expect("sim_12", ext(4'd12));

    // Simultaneous push and pop while empty: pop ignored, data held
    press(4'd5, 1'b1);
    check("sim_empty_valid", 32'(cap_valid), 32'd0);
    check("sim_empty_hold", 32'(cap_data), 32'(ext(4'd12)));
    check("sim_empty_count", 32'(cap_count), 32'd1);
    pop_expect("sim_5", ext(4'd5));

    // Reset mid-operation with a partial press in the debouncer
    press(4'd1, 1'b0); press(4'd2, 1'b0); press(4'd3, 1'b0);
    check("mid_count3", 32'(count), 32'd3);
    sw = 4'd9;
    btn_push = 1'b1;
    repeat (4) @(negedge clk);
    btn_push = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    repeat (15) @(negedge clk);
    check("mid_no_push", 32'(count), 32'd0);
    check("mid_no_valid", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
